// File: rtl/uart_rx_stream_pkg.sv
// Shared state encoding and divider helper for the UART receive stream front end.
package uart_rx_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } uart_rx_state_e;

   localparam int UART_OVERSAMPLE = 16;

   // Clock cycles per oversample tick, rounded to nearest.
   function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
      longint den;
      den = baud * os;
      return int'((clk_freq + den / 2) / den);
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             push_ok, pop_ok;

   always_comb begin
      pop_ok   = pop && (level_q != '0);
      push_ok  = push && ((level_q != FULL_LVL) || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);
   assign level = level_q;

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 receiver feeding a byte FIFO, replayed to the parser as paced one-cycle strobes.
module uart_rx_stream
   import uart_rx_stream_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int FIFO_DEPTH = 16,
   parameter int DRAIN_GAP  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   output logic [7:0]                    data,
   output logic                          dataReady,
   output logic                          overflow,
   output logic                          frameError,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam int GW  = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
   localparam logic [OSW-1:0] SUB_MID   = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] SUB_LAST  = OSW'(OVERSAMPLE - 1);
   localparam logic [GW-1:0]  GAP_LOAD  = GW'(DRAIN_GAP - 1);

   uart_rx_state_e state_q, state_d;
   logic           sync1_q, sync1_d, sync2_q, sync2_d;
   logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [OSW-1:0] sub_q, sub_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           frame_err_q, frame_err_d;
   logic           overflow_q, overflow_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [7:0]     data_q, data_d;
   logic           data_ready_q, data_ready_d;
   logic           rx_s, tick, push, pop;
   logic [7:0]     fifo_rdata;
   logic           fifo_full, fifo_empty;

   assign rx_s = sync2_q;
   assign tick = (tick_cnt_q == TICK_LAST);

   always_comb begin
      sync1_d     = rxd;
      sync2_d     = sync1_q;
      state_d     = state_q;
      sub_d       = sub_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
      unique case (state_q)
         IDLE: begin
            // Restart the tick phase so samples land relative to the start edge.
            if (!rx_s) begin
               state_d    = START;
               sub_d      = '0;
               tick_cnt_d = '0;
            end
         end
         START: begin
            if (tick) begin
               if (sub_q == SUB_MID) begin
                  sub_d   = '0;
                  bit_d   = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  sub_d = sub_q + OSW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (sub_q == SUB_LAST) begin
                  sub_d   = '0;
                  shift_d = {rx_s, shift_q[7:1]};
                  if (bit_q == 3'd7) state_d = STOP;
                  else bit_d = bit_q + 3'd1;
               end else begin
                  sub_d = sub_q + OSW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (sub_q == SUB_LAST) begin
                  sub_d = '0;
                  if (rx_s) begin
                     push    = 1'b1;
                     state_d = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_IDLE;
                  end
               end else begin
                  sub_d = sub_q + OSW'(1);
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Drain pacing: the parser cannot stall, so pops are spaced by the gap counter.
   always_comb begin
      pop          = !fifo_empty && (gap_q == '0);
      overflow_d   = overflow_q || (push && fifo_full && !pop);
      data_ready_d = pop;
      data_d       = pop ? fifo_rdata : data_q;
      if (pop) gap_d = GAP_LOAD;
      else if (gap_q != '0) gap_d = gap_q - GW'(1);
      else gap_d = gap_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         tick_cnt_q   <= '0;
         state_q      <= IDLE;
         sub_q        <= '0;
         bit_q        <= '0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
         gap_q        <= '0;
         data_q       <= '0;
         data_ready_q <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         tick_cnt_q   <= tick_cnt_d;
         state_q      <= state_d;
         sub_q        <= sub_d;
         bit_q        <= bit_d;
         frame_err_q  <= frame_err_d;
         overflow_q   <= overflow_d;
         gap_q        <= gap_d;
         data_q       <= data_d;
         data_ready_q <= data_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (shift_q),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifoLevel)
   );

   assign data       = data_q;
   assign dataReady  = data_ready_q;
   assign overflow   = overflow_q;
   assign frameError = frame_err_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench: default-rate receiver, a fast-rate receiver, and a slow-drain receiver for overflow.
module tb_uart_rx_stream;
   import uart_rx_stream_pkg::*;

   localparam int BIT_A = 864;   // 16 ticks x DIV 54
   localparam int BIT_B = 64;    // 16 ticks x DIV 4
   localparam int BIT_C = 16;    // 8 ticks x DIV 2
   localparam int GAP_C = 3200;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
   logic [7:0] data_a, data_b, data_c;
   logic       dr_a, dr_b, dr_c;
   logic       ov_a, ov_b, ov_c;
   logic       fe_a, fe_b, fe_c;
   logic [4:0] lvl_a, lvl_b, lvl_c;

   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         fe_cnt_a = 0, fe_cnt_b = 0, fe_cnt_c = 0;
   logic [7:0] qa[$], qb[$], qc[$];
   int         tb_[$], tc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   uart_rx_stream dut_a (
      .clk(clk), .rst(rst), .rxd(rxd_a), .data(data_a), .dataReady(dr_a),
      .overflow(ov_a), .frameError(fe_a), .fifoLevel(lvl_a)
   );
   uart_rx_stream #(
      .CLK_FREQ(100_000_000), .BAUD(1_562_500), .OVERSAMPLE(16), .FIFO_DEPTH(16), .DRAIN_GAP(4)
   ) dut_b (
      .clk(clk), .rst(rst), .rxd(rxd_b), .data(data_b), .dataReady(dr_b),
      .overflow(ov_b), .frameError(fe_b), .fifoLevel(lvl_b)
   );
   uart_rx_stream #(
      .CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(8), .FIFO_DEPTH(16), .DRAIN_GAP(GAP_C)
   ) dut_c (
      .clk(clk), .rst(rst), .rxd(rxd_c), .data(data_c), .dataReady(dr_c),
      .overflow(ov_c), .frameError(fe_c), .fifoLevel(lvl_c)
   );

   always @(negedge clk) begin
      if (dr_a) qa.push_back(data_a);
      if (dr_b) begin qb.push_back(data_b); tb_.push_back(cyc); end
      if (dr_c) begin qc.push_back(data_c); tc.push_back(cyc); end
      if (fe_a) fe_cnt_a++;
      if (fe_b) fe_cnt_b++;
      if (fe_c) fe_cnt_c++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
         $error("check %s did not hold", tag);
      end
   endtask

   function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 8'hxx;
   endfunction

   task automatic drive_rx(input int sel, input logic v);
      case (sel)
         0: rxd_a = v;
         1: rxd_b = v;
         default: rxd_c = v;
      endcase
   endtask

   task automatic send_byte(input int sel, input int bitc, input logic [7:0] b, input logic stopv);
      logic [9:0] fr;
      fr = {stopv, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive_rx(sel, fr[i]);
         repeat (bitc) @(negedge clk);
      end
      drive_rx(sel, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] exp_c [20];
      logic [7:0] exp_b [4];
      int         min_gap, bad_gaps;

      exp_b[0] = 8'h1B; exp_b[1] = 8'h5B; exp_b[2] = 8'h32; exp_b[3] = 8'h4A;
      for (int i = 0; i < 20; i++) exp_c[i] = 8'(i * 37 + 5);

      rst = 1'b0;
      idle(4);
      rst = 1'b1;
      idle(1);
      check("rst_data", 32'(data_a), 32'h00);
      check("rst_ready", 32'(dr_a), 32'h0);
      check("rst_overflow", 32'(ov_a), 32'h0);
      check("rst_frame_err", 32'(fe_a), 32'h0);
      check("rst_level", 32'(lvl_a), 32'h0);

      // Single byte at the default line rate
      send_byte(0, BIT_A, 8'h41, 1'b1);
      idle(2 * BIT_A);
      check("a41_count", 32'(qa.size()), 32'd1);
      check("a41_data", 32'(qget(qa, 0)), 32'h41);
      check("a41_frame_err", 32'(fe_cnt_a), 32'd0);
      check("a41_level", 32'(lvl_a), 32'd0);

      // Start-bit glitch of three ticks
      rxd_a = 1'b0;
      idle(3 * 54);
      rxd_a = 1'b1;
      idle(2 * BIT_A);
      check("glitch_count", 32'(qa.size()), 32'd1);
      check("glitch_frame_err", 32'(fe_cnt_a), 32'd0);
      check("glitch_state", 32'(dut_a.state_q), 32'(IDLE));

      // Four bytes back to back
      for (int i = 0; i < 4; i++) send_byte(1, BIT_B, exp_b[i], 1'b1);
      idle(2 * BIT_B);
      check("b2b_count", 32'(qb.size()), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("b2b_data%0d", i), 32'(qget(qb, i)), 32'(exp_b[i]));
      min_gap = 1 << 30;
      for (int i = 1; i < tb_.size(); i++) if (tb_[i] - tb_[i-1] < min_gap) min_gap = tb_[i] - tb_[i-1];
      check("b2b_spacing_ge4", 32'(min_gap >= 4), 32'd1);
      check("b2b_level", 32'(lvl_b), 32'd0);

      // Stop bit low, then a good byte
      send_byte(1, BIT_B, 8'h55, 1'b0);
      idle(2 * BIT_B);
      check("ferr_pulses", 32'(fe_cnt_b), 32'd1);
      check("ferr_no_data", 32'(qb.size()), 32'd4);
      send_byte(1, BIT_B, 8'h20, 1'b1);
      idle(2 * BIT_B);
      check("ferr_next_count", 32'(qb.size()), 32'd5);
      check("ferr_next_data", 32'(qget(qb, 4)), 32'h20);

      // Reset in the middle of the data bits of 0x7E
      rxd_b = 1'b0; idle(BIT_B);
      rxd_b = 1'b0; idle(BIT_B);
      rxd_b = 1'b1; idle(BIT_B / 2);
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(1);
      check("mid_rst_data", 32'(data_b), 32'h00);
      check("mid_rst_ready", 32'(dr_b), 32'h0);
      check("mid_rst_level", 32'(lvl_b), 32'h0);
      check("mid_rst_overflow", 32'(ov_b), 32'h0);
      check("mid_rst_frame_err", 32'(fe_b), 32'h0);
      idle(12 * BIT_B);
      check("mid_rst_no_partial", 32'(qb.size()), 32'd5);
      send_byte(1, BIT_B, 8'h31, 1'b1);
      idle(2 * BIT_B);
      check("mid_rst_next_count", 32'(qb.size()), 32'd6);
      check("mid_rst_next_data", 32'(qget(qb, 5)), 32'h31);
      check("mid_rst_frame_err_cnt", 32'(fe_cnt_b), 32'd1);

      // Twenty bytes into a slow drain: byte 0 drains at once, bytes 1-16 fill the FIFO, 17-19 drop
      for (int i = 0; i < 20; i++) send_byte(2, BIT_C, exp_c[i], 1'b1);
      idle(2);
      check("ovf_level_full", 32'(lvl_c), 32'd16);
      check("ovf_sticky", 32'(ov_c), 32'd1);
      for (int i = 0; i < 60000 && qc.size() < 17; i++) idle(1);
      idle(100);
      check("ovf_count", 32'(qc.size()), 32'd17);
      for (int i = 0; i < 17; i++) check($sformatf("ovf_data%0d", i), 32'(qget(qc, i)), 32'(exp_c[i]));
      bad_gaps = 0;
      for (int i = 1; i < tc.size(); i++) if (tc[i] - tc[i-1] != GAP_C) bad_gaps++;
      check("ovf_pacing", 32'(bad_gaps), 32'd0);
      check("ovf_level_empty", 32'(lvl_c), 32'd0);
      check("ovf_still_set", 32'(ov_c), 32'd1);
      check("ovf_frame_err", 32'(fe_cnt_c), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
